// File: rtl/counter_down_sync.sv
// Down counter decremented once per rising edge of an asynchronous request
// input, with synchronous load, optional wrap with borrow pulse, and zero flag.
module counter_down_sync #(
  parameter int WIDTH = 2,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] state,
  output logic             borrow,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [WIDTH-1:0] r_state;
  logic             r_borrow;

  logic             w_rise;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_next_state;
  logic             w_next_borrow;

  // Two-flop synchronizer plus history flop; keeps running during load.
  always_ff @(posedge clk) begin
    if (rst == 1'b0) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= x;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise    = r_s2 & ~r_s3;
  assign w_at_zero = (r_state == ALL_ZERO);

  // Next count and borrow: load beats a rise event, and a coincident rise is dropped.
  always_comb begin
    w_next_state  = r_state;
    w_next_borrow = 1'b0;
    if (load == 1'b1) begin
      w_next_state  = din;
      w_next_borrow = 1'b0;
    end else if (w_rise == 1'b1) begin
      if (w_at_zero == 1'b0) begin
        w_next_state  = r_state - ONE;
        w_next_borrow = 1'b0;
      end else if (WRAP == 1'b1) begin
        w_next_state  = ALL_ONES;
        w_next_borrow = 1'b1;
      end else begin
        w_next_state  = ALL_ZERO;
        w_next_borrow = 1'b0;
      end
    end else begin
      w_next_state  = r_state;
      w_next_borrow = 1'b0;
    end
  end

  // Count and borrow registers.
  always_ff @(posedge clk) begin
    if (rst == 1'b0) begin
      r_state  <= ALL_ZERO;
      r_borrow <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_borrow <= w_next_borrow;
    end
  end

  assign state  = r_state;
  assign borrow = r_borrow;
  assign zero   = w_at_zero;

endmodule

// File: tb/tb_counter_down_sync.sv
// Scoreboard bench: stimulus pushes the expected count/borrow for each edge,
// a negedge monitor pops and compares against the selected DUT instance.
module tb_counter_down_sync;

  typedef struct {
    int         sel;
    logic [1:0] st;
    logic       bo;
  } exp_t;

  logic       clk;
  logic       rsta, xa, loada;
  logic [1:0] dina;
  logic [1:0] sta;
  logic       boa, zea;
  logic       rstb, xb, loadb;
  logic [1:0] dinb;
  logic [1:0] stb;
  logic       bob, zeb;

  exp_t sb[$];
  int   total;
  int   bad;

  counter_down_sync #(.WIDTH(2), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rsta), .x(xa), .load(loada), .din(dina),
    .state(sta), .borrow(boa), .zero(zea)
  );

  counter_down_sync #(.WIDTH(2), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rstb), .x(xb), .load(loadb), .din(dinb),
    .state(stb), .borrow(bob), .zero(zeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every expectation against the outputs after its edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [3:0] act;
      logic [3:0] req;
      e   = sb.pop_front();
      act = (e.sel == 0) ? {sta, boa, zea} : {stb, bob, zeb};
      req = {e.st, e.bo, (e.st == 2'd0)};
      total = total + 1;
      if (act !== req) begin
        bad = bad + 1;
        $display("FAIL dut%0d edge#%0d {state,borrow,zero}: got %b want %b",
                 e.sel, total, act, req);
      end
    end
  end

  task automatic tick(input int sel, input logic [1:0] st, input logic bo);
    exp_t e;
    @(posedge clk);
    e.sel = sel;
    e.st  = st;
    e.bo  = bo;
    sb.push_back(e);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] seq_st [5];
    logic       seq_bo [5];
    logic [1:0] prev;
    total = 0;
    bad   = 0;
    seq_st = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    seq_bo = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    rsta = 1'b0; xa = 1'b0; loada = 1'b0; dina = 2'd0;
    rstb = 1'b0; xb = 1'b0; loadb = 1'b0; dinb = 2'd0;

    // Reset, then x toggling every two clocks: 0,3,2,1,0,3.
    tick(0, 2'd0, 1'b0);
    rsta = 1'b1;
    prev = 2'd0;
    for (int k = 0; k < 5; k++) begin
      xa = 1'b1;
      tick(0, prev, 1'b0);
      tick(0, prev, 1'b0);
      xa = 1'b0;
      tick(0, seq_st[k], seq_bo[k]);
      tick(0, seq_st[k], 1'b0);
      prev = seq_st[k];
    end

    // x held high ten cycles from zero: one wrap to 3, then hold.
    rsta = 1'b0;
    tick(0, 2'd0, 1'b0);
    rsta = 1'b1;
    xa = 1'b1;
    tick(0, 2'd0, 1'b0);
    tick(0, 2'd0, 1'b0);
    tick(0, 2'd3, 1'b1);
    for (int i = 0; i < 7; i++) tick(0, 2'd3, 1'b0);
    xa = 1'b0;
    tick(0, 2'd3, 1'b0);
    tick(0, 2'd3, 1'b0);

    // Load coincident with a rise event: rise discarded.
    xa = 1'b1;
    tick(0, 2'd3, 1'b0);
    tick(0, 2'd3, 1'b0);
    loada = 1'b1; dina = 2'd2;
    tick(0, 2'd2, 1'b0);
    loada = 1'b0; xa = 1'b0;
    tick(0, 2'd2, 1'b0);
    tick(0, 2'd2, 1'b0);
    xa = 1'b1;
    tick(0, 2'd2, 1'b0);
    tick(0, 2'd2, 1'b0);
    tick(0, 2'd1, 1'b0);
    xa = 1'b0;
    tick(0, 2'd1, 1'b0);
    tick(0, 2'd1, 1'b0);

    // Reset while a rise sits in the synchronizer, x falls before release.
    xa = 1'b1;
    tick(0, 2'd1, 1'b0);
    rsta = 1'b0;
    tick(0, 2'd0, 1'b0);
    rsta = 1'b1; xa = 1'b0;
    for (int i = 0; i < 4; i++) tick(0, 2'd0, 1'b0);

    // x held high through reset release: single wrap three edges later.
    xa = 1'b1; rsta = 1'b0;
    tick(0, 2'd0, 1'b0);
    tick(0, 2'd0, 1'b0);
    rsta = 1'b1;
    tick(0, 2'd0, 1'b0);
    tick(0, 2'd0, 1'b0);
    tick(0, 2'd3, 1'b1);
    tick(0, 2'd3, 1'b0);
    tick(0, 2'd3, 1'b0);
    xa = 1'b0;
    tick(0, 2'd3, 1'b0);

    // Plain load of 1.
    loada = 1'b1; dina = 2'd1;
    tick(0, 2'd1, 1'b0);
    loada = 1'b0;
    tick(0, 2'd1, 1'b0);

    // Saturating instance: 1 -> 0, then holds 0 with no borrow.
    tick(1, 2'd0, 1'b0);
    rstb = 1'b1;
    loadb = 1'b1; dinb = 2'd1;
    tick(1, 2'd1, 1'b0);
    loadb = 1'b0;
    for (int k = 0; k < 2; k++) begin
      xb = 1'b1;
      tick(1, (k == 0) ? 2'd1 : 2'd0, 1'b0);
      tick(1, (k == 0) ? 2'd1 : 2'd0, 1'b0);
      xb = 1'b0;
      tick(1, 2'd0, 1'b0);
      tick(1, 2'd0, 1'b0);
    end

    @(negedge clk);
    #1;
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
